// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the coordinate type shared by the
// raster generator and its consumers.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int H_TOTAL  = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL  = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  // Sync windows are inclusive: [START, END]
  localparam int HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int HS_END   = HS_START + DEF_H_SYNC - 1;
  localparam int VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int VS_END   = VS_START + DEF_V_SYNC - 1;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register used to align blank and sync with the sprite
// mapper pipeline; DEPTH=0 degenerates to a pass-through.
module vga_delay_line #(
  parameter int                WIDTH     = 1,
  parameter int                DEPTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      // Gate with reset so the output still shows the inactive value in reset.
      assign q = reset_n ? d : RESET_VAL;
    end else begin : g_pipe
      logic [DEPTH-1:0][WIDTH-1:0] pipe_q, pipe_d;

      always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = d;
        for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
      end

      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) pipe_q <= {DEPTH{RESET_VAL}};
        else          pipe_q <= pipe_d;
      end

      assign q = pipe_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480 raster counter with delay-matched blank/sync, line/frame strobes and
// a free-running frame counter for sprite animation.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE   = DEF_H_VISIBLE,
  parameter int H_FRONT     = DEF_H_FRONT,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BACK      = DEF_H_BACK,
  parameter int V_VISIBLE   = DEF_V_VISIBLE,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int BLANK_DELAY = 1,
  parameter int SYNC_DELAY  = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam coord_t X_LAST = coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam coord_t Y_LAST = coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam coord_t X_VIS  = coord_t'(H_VISIBLE);
  localparam coord_t Y_VIS  = coord_t'(V_VISIBLE);
  localparam coord_t HS_LO  = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_HI  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_LO  = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_HI  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  coord_t     x_q, x_d, y_q, y_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       vis, hs_raw, vs_raw;

  always_comb begin
    x_d         = x_q + 10'd1;
    y_d         = y_q;
    frame_cnt_d = frame_cnt_q;
    if (x_q == X_LAST) begin
      x_d = '0;
      if (y_q == Y_LAST) begin
        y_d         = '0;
        frame_cnt_d = frame_cnt_q + 8'd1;
      end else begin
        y_d = y_q + 10'd1;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q         <= '0;
      y_q         <= '0;
      frame_cnt_q <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    vis    = (x_q < X_VIS) && (y_q < Y_VIS);
    hs_raw = !((x_q >= HS_LO) && (x_q <= HS_HI));
    vs_raw = !((y_q >= VS_LO) && (y_q <= VS_HI));
  end

  vga_delay_line #(.WIDTH(1), .DEPTH(BLANK_DELAY), .RESET_VAL(1'b0)) u_blank_dly (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .d       (vis),
    .q       (blank)
  );

  vga_delay_line #(.WIDTH(2), .DEPTH(SYNC_DELAY), .RESET_VAL(2'b11)) u_sync_dly (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .d       ({hs_raw, vs_raw}),
    .q       ({hs, vs})
  );

  // Counters sit at (0,0) during reset; the reset_n term keeps the strobes low
  // there while letting them fire in the first cycle after release.
  assign line_start  = reset_n && (x_q == '0);
  assign frame_start = line_start && (y_q == '0);
  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed checks of the raster counter, blank/sync alignment, strobes,
// frame counter wrap and mid-line reset.
module tb_vga_timing_gen;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] DrawX, DrawY;
  logic       blank, hs, vs, line_start, frame_start;
  logic [7:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  vga_timing_gen dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .hs          (hs),
    .vs          (vs),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  task automatic wait_xy(input int x, input int y, input int lim, input string tag);
    int n;
    n = 0;
    while (!(DrawX == 10'(x) && DrawY == 10'(y)) && n < lim) begin
      @(negedge vga_clk);
      n++;
    end
    if (n >= lim) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic set_y(input logic [9:0] y);
    force dut.y_q = y;
    step(1);
    release dut.y_q;
  endtask

  initial begin
    int n, hs_lo, vs_lo, ls_cnt, fs_cnt, blk_bad;
    logic v_a, v_b, v_c, v_d;

    // Reset state
    step(3);
    chk("rst_x", DrawX, 0);      chk("rst_y", DrawY, 0);
    chk("rst_blank", blank, 0);  chk("rst_hs", hs, 1);
    chk("rst_vs", vs, 1);        chk("rst_ls", line_start, 0);
    chk("rst_fs", frame_start, 0); chk("rst_fc", frame_cnt, 0);

    // Release: first cycle at (0,0) with strobes high
    reset_n = 1'b1;
    #1;
    chk("rel_x", DrawX, 0);        chk("rel_fs", frame_start, 1);
    chk("rel_ls", line_start, 1);  chk("rel_blank", blank, 0);
    chk("rel_hs", hs, 1);          chk("rel_vs", vs, 1);
    step(1);
    chk("e1_x", DrawX, 1);  chk("e1_blank", blank, 1);  chk("e1_fs", frame_start, 0);
    step(4);
    chk("e5_x", DrawX, 5);

    // Horizontal boundaries on line 0
    wait_xy(640, 0, 1000, "w640");
    chk("blank_at640", blank, 1);
    step(1);
    chk("blank_at641", blank, 0);
    wait_xy(657, 0, 1000, "w657");
    chk("hs_at657", hs, 1);
    step(1);
    chk("hs_at658", hs, 0);
    wait_xy(753, 0, 1000, "w753");
    chk("hs_at753", hs, 0);
    step(1);
    chk("hs_at754", hs, 1);
    wait_xy(799, 0, 1000, "w799");
    step(1);
    chk("wrap_x", DrawX, 0);  chk("wrap_y", DrawY, 1);  chk("wrap_ls", line_start, 1);

    // One full line: period and hsync width
    hs_lo = 0; ls_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      if (!hs) hs_lo++;
      if (line_start) ls_cnt++;
      step(1);
    end
    chk("hs_width", hs_lo, 96);  chk("ls_per_line", ls_cnt, 1);
    chk("line_x", DrawX, 0);     chk("line_y", DrawY, 2);

    // Jump to line 479 and run to the end of the frame
    set_y(10'd479);
    chk("jump_y", DrawY, 479);
    n = 0; vs_lo = 0; blk_bad = 0; fs_cnt = 0;
    v_a = 1'b0; v_b = 1'b1; v_c = 1'b1; v_d = 1'b0;
    while (n < 40000) begin
      @(negedge vga_clk);
      n++;
      if (!vs) vs_lo++;
      if (blank && DrawY >= 10'd480) blk_bad++;
      if (frame_start) fs_cnt++;
      if (DrawX == 10'd1 && DrawY == 10'd490) v_a = vs;
      if (DrawX == 10'd2 && DrawY == 10'd490) v_b = vs;
      if (DrawX == 10'd1 && DrawY == 10'd492) v_c = vs;
      if (DrawX == 10'd2 && DrawY == 10'd492) v_d = vs;
      if (DrawX == 10'd0 && DrawY == 10'd0) break;
    end
    chk("frame_wrap_reached", int'(DrawX == 10'd0 && DrawY == 10'd0), 1);
    chk("vs_width", vs_lo, 1600);
    chk("vs_pre_edge", v_a, 1);  chk("vs_fall", v_b, 0);
    chk("vs_last_low", v_c, 0);  chk("vs_rise", v_d, 1);
    chk("blank_vert", blk_bad, 0);
    chk("fs_once", fs_cnt, 1);
    chk("fc_1", frame_cnt, 1);
    chk("f1_blank0", blank, 0);
    step(1);
    chk("f1_blank1", blank, 1);

    // Second frame end
    set_y(10'd524);
    wait_xy(0, 0, 1000, "wf2");
    chk("fc_2", frame_cnt, 2);

    // Frame counter wrap
    step(3);
    force dut.frame_cnt_q = 8'd255;
    force dut.y_q = 10'd524;
    step(1);
    release dut.frame_cnt_q;
    release dut.y_q;
    chk("fc_255", frame_cnt, 255);
    wait_xy(0, 0, 1000, "wfc");
    chk("fc_wrap", frame_cnt, 0);

    // Mid-line reset with hs low pending in the delay line
    set_y(10'd200);
    wait_xy(300, 200, 1000, "w300");
    chk("mid_x300", DrawX, 300);
    wait_xy(657, 200, 1000, "w657b");
    chk("pend_hs", hs, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_x", DrawX, 0);      chk("ar_y", DrawY, 0);
    chk("ar_hs", hs, 1);        chk("ar_vs", vs, 1);
    chk("ar_blank", blank, 0);  chk("ar_ls", line_start, 0);
    chk("ar_fs", frame_start, 0); chk("ar_fc", frame_cnt, 0);
    step(3);
    chk("ar_hold_hs", hs, 1);
    reset_n = 1'b1;
    #1;
    chk("ar_rel_fs", frame_start, 1);
    hs_lo = 0; vs_lo = 0;
    for (int i = 0; i < 650; i++) begin
      step(1);
      if (!hs) hs_lo++;
      if (!vs) vs_lo++;
    end
    chk("ar_no_hs", hs_lo, 0);  chk("ar_no_vs", vs_lo, 0);
    chk("ar_x650", DrawX, 650); chk("ar_y0", DrawY, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
